// File: rtl/led_pattern_driver.sv
// Single-LED pattern driver: off / steady / blink / counted pulse burst, with 8-bit PWM
// brightness on every lit phase. Commands arrive over valid/ready; led_n is active low.
//
// state      | meaning
// OFF        | LED dark, ready for commands
// STEADY     | LED lit continuously
// BLINK_ON   | lit phase of an endless blink
// BLINK_OFF  | dark phase of an endless blink
// PULSE_ON   | lit phase of a burst pair, not ready
// PULSE_OFF  | dark phase of a burst pair, not ready
module led_pattern_driver #(
  parameter int TICK_CYCLES = 27000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [1:0] i_cmd_mode,
  input  logic [7:0] i_cmd_level,
  input  logic [7:0] i_cmd_period,
  input  logic [7:0] i_cmd_count,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_led_n
);

  localparam int TW = $clog2(TICK_CYCLES);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  localparam logic [2:0] ST_OFF       = 3'd0;
  localparam logic [2:0] ST_STEADY    = 3'd1;
  localparam logic [2:0] ST_BLINK_ON  = 3'd2;
  localparam logic [2:0] ST_BLINK_OFF = 3'd3;
  localparam logic [2:0] ST_PULSE_ON  = 3'd4;
  localparam logic [2:0] ST_PULSE_OFF = 3'd5;

  logic [2:0]    r_state;
  logic [7:0]    r_level;
  logic [7:0]    r_period;
  logic [7:0]    r_remaining;
  logic [TW-1:0] r_tick_cnt;
  logic [7:0]    r_phase_cnt;
  logic [7:0]    r_pwm_cnt;
  logic          r_done;
  logic          r_led_n;

  logic       w_ready;
  logic       w_accept;
  logic       w_tick;
  logic       w_timed;
  logic [7:0] w_period_eff;
  logic       w_phase_last;
  logic       w_phase_end;
  logic       w_lit;
  logic       w_pwm_on;

  assign w_ready      = (r_state != ST_PULSE_ON) && (r_state != ST_PULSE_OFF);
  assign w_accept     = i_cmd_valid && w_ready;
  assign w_tick       = (r_tick_cnt == TICK_LAST);
  assign w_timed      = (r_state == ST_BLINK_ON) || (r_state == ST_BLINK_OFF) ||
                        (r_state == ST_PULSE_ON) || (r_state == ST_PULSE_OFF);
  assign w_period_eff = (r_period == 8'd0) ? 8'd1 : r_period;
  // 9-bit compare so period=255 cannot wrap the phase counter
  assign w_phase_last = (({1'b0, r_phase_cnt} + 9'd1) == {1'b0, w_period_eff});
  assign w_phase_end  = w_tick && w_timed && w_phase_last;
  assign w_lit        = (r_state == ST_STEADY) || (r_state == ST_BLINK_ON) ||
                        (r_state == ST_PULSE_ON);
  assign w_pwm_on     = (r_level == 8'd255) || (r_pwm_cnt < r_level);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_OFF;
      r_level     <= 8'd0;
      r_period    <= 8'd0;
      r_remaining <= 8'd0;
      r_tick_cnt  <= '0;
      r_phase_cnt <= 8'd0;
      r_pwm_cnt   <= 8'd0;
      r_done      <= 1'b0;
      r_led_n     <= 1'b1;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
      r_led_n   <= ~(w_lit & w_pwm_on);
      r_done    <= 1'b0;
      if (w_accept) begin
        // a tick landing on the accept edge is dropped so the first phase is full length
        r_tick_cnt  <= '0;
        r_phase_cnt <= 8'd0;
        r_level     <= i_cmd_level;
        r_period    <= i_cmd_period;
        r_remaining <= i_cmd_count;
        case (i_cmd_mode)
          2'd0:    r_state <= ST_OFF;
          2'd1:    r_state <= ST_STEADY;
          2'd2:    r_state <= ST_BLINK_ON;
          default: begin
            if (i_cmd_count == 8'd0) begin
              r_state <= ST_OFF;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_PULSE_ON;
            end
          end
        endcase
      end else begin
        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
        if (w_phase_end) begin
          r_phase_cnt <= 8'd0;
          case (r_state)
            ST_BLINK_ON:  r_state <= ST_BLINK_OFF;
            ST_BLINK_OFF: r_state <= ST_BLINK_ON;
            ST_PULSE_ON:  r_state <= ST_PULSE_OFF;
            ST_PULSE_OFF: begin
              r_remaining <= r_remaining - 8'd1;
              if (r_remaining == 8'd1) begin
                r_state <= ST_OFF;
                r_done  <= 1'b1;
              end else begin
                r_state <= ST_PULSE_ON;
              end
            end
            default:      r_state <= r_state;
          endcase
        end else if (w_tick && w_timed) begin
          r_phase_cnt <= r_phase_cnt + 8'd1;
        end
      end
    end
  end

  assign o_cmd_ready = w_ready;
  assign o_busy      = ~w_ready;
  assign o_done      = r_done;
  assign o_led_n     = r_led_n;

endmodule

// File: tb/tb_led_pattern_driver.sv
// Bench for led_pattern_driver: driver queues each issued command, a monitor process
// pops it on the modelled accept edge and compares every cycle against a timeline model.
module tb_led_pattern_driver;
  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_mode = 2'd0;
  logic [7:0] cmd_level = 8'd0;
  logic [7:0] cmd_period = 8'd0;
  logic [7:0] cmd_count = 8'd0;
  logic       cmd_ready;
  logic       busy;
  logic       done;
  logic       led_n;

  always #5 clk = ~clk;

  led_pattern_driver #(.TICK_CYCLES(T)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_mode  (cmd_mode),
    .i_cmd_level (cmd_level),
    .i_cmd_period(cmd_period),
    .i_cmd_count (cmd_count),
    .o_busy      (busy),
    .o_done      (done),
    .o_led_n     (led_n)
  );

  typedef struct {
    int mode;
    int level;
    int period;
    int count;
  } cmd_t;

  cmd_t q_cmd[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: outputs are a function of edges elapsed since the last accept or reset.
  bit   m_init = 1'b0;
  bit   m_have = 1'b0;
  bit   m_ready = 1'b1;
  bit   m_lit = 1'b0;
  bit   e_led = 1'b1;
  bit   e_busy = 1'b0;
  bit   e_done = 1'b0;
  bit   m_nxt = 1'b1;
  int   m_edge = 0;
  int   m_rlast = 0;
  int   m_a = 0;
  int   m_pwm = 0;
  int   m_k = 0;
  int   m_len = 1;
  cmd_t m_c = '{0, 0, 0, 0};

  initial begin
    forever begin
      @(posedge clk);
      m_edge++;
      m_nxt = !(m_lit && (m_c.level == 255 || m_pwm < m_c.level));
      if (!rst_n) begin
        m_init  = 1'b1;
        m_rlast = m_edge;
        m_have  = 1'b0;
        m_c     = '{0, 0, 0, 0};
        e_led   = 1'b1;
      end else begin
        if (m_init && cmd_valid && m_ready) begin
          if (q_cmd.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty at t=%0t: got accept expected queued command", $time);
          end else begin
            m_c    = q_cmd.pop_front();
            m_have = 1'b1;
            m_a    = m_edge;
          end
        end
        e_led = m_nxt;
      end
      m_pwm  = (m_edge - m_rlast) % 256;
      m_lit  = 1'b0;
      e_busy = 1'b0;
      e_done = 1'b0;
      if (m_have) begin
        m_k   = m_edge - m_a;
        m_len = ((m_c.period == 0) ? 1 : m_c.period) * T;
        case (m_c.mode)
          1: m_lit = 1'b1;
          2: m_lit = ((m_k / m_len) % 2) == 0;
          3: begin
            if (m_c.count == 0) begin
              e_done = (m_k == 0);
            end else begin
              e_busy = m_k < 2 * m_c.count * m_len;
              m_lit  = e_busy && (((m_k / m_len) % 2) == 0);
              e_done = (m_k == 2 * m_c.count * m_len);
            end
          end
          default: m_lit = 1'b0;
        endcase
      end
      m_ready = !e_busy;
      @(negedge clk);
      if (m_init) begin
        check("led_n", {31'd0, led_n}, {31'd0, e_led});
        check("busy", {31'd0, busy}, {31'd0, e_busy});
        check("done", {31'd0, done}, {31'd0, e_done});
        check("cmd_ready", {31'd0, cmd_ready}, {31'd0, m_ready});
      end
    end
  end

  task automatic send(input int mode, input int level, input int period, input int count);
    cmd_t c;
    int   n;
    c = '{mode, level, period, count};
    @(negedge clk);
    q_cmd.push_back(c);
    cmd_mode   = 2'(mode);
    cmd_level  = 8'(level);
    cmd_period = 8'(period);
    cmd_count  = 8'(count);
    cmd_valid  = 1'b1;
    n = 0;
    while (!cmd_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout at t=%0t: got no ready within %0d cycles expected ready", $time, n);
      void'(q_cmd.pop_back());
      cmd_valid = 1'b0;
    end else begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int lv;
    cmd_valid = 1'b1;
    cmd_mode  = 2'd1;
    cmd_level = 8'd255;
    repeat (3) @(negedge clk);
    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    idle(5);

    send(1, 255, 0, 0);
    idle(1000);
    send(1, 64, 0, 0);
    idle(600);

    send(2, 255, 3, 0);
    idle(30);
    send(0, 0, 0, 0);
    idle(10);

    send(3, 255, 1, 3);
    send(1, 255, 0, 0);
    idle(20);

    send(3, 255, 5, 0);
    idle(10);
    send(2, 255, 0, 0);
    idle(60);
    send(2, 255, 1, 0);
    idle(60);

    send(3, 255, 2, 4);
    idle(18);
    pulse_reset();
    idle(10);

    send(2, 0, 1, 0);
    idle(40);
    send(2, 200, 255, 0);
    idle(2100);
    send(3, 255, 1, 255);
    idle(10);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0:       lv = 0;
        1:       lv = 255;
        default: lv = int'($urandom_range(1, 254));
      endcase
      send(int'($urandom_range(0, 3)), lv, int'($urandom_range(0, 4)),
           int'($urandom_range(0, 4)));
      idle(int'($urandom_range(0, 80)));
    end
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog at t=%0t: got no finish expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
